// File: rtl/serializer_pkg.sv
// serializer_pkg: shared FSM state type and word-order index helper for the serializer.
package serializer_pkg;

    typedef enum logic {IDLE, SHIFT} ser_state_e;

    // Frame index carried by beat idx of an n-word frame: dir=1 sends the top word first.
    function automatic int word_sel(input logic dir, input int idx, input int n);
        return dir ? n - 1 - idx : idx;
    endfunction

endpackage

// File: rtl/ser_frame_buf.sv
// ser_frame_buf: one-frame holding register with valid flag and the frame's own latched dir.
module ser_frame_buf
    import serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARL_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  unload,
    input  logic                  load_dir,
    input  logic [DATA_WIDTH-1:0] load_par [PARL_WIDTH],
    output logic                  hold_vld,
    output logic                  hold_dir,
    output logic [DATA_WIDTH-1:0] hold_par [PARL_WIDTH]
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld <= 1'b0;
            hold_dir <= 1'b0;
            hold_par <= '{default: '0};
        end else if (load) begin
            hold_vld <= 1'b1;
            hold_dir <= load_dir;
            hold_par <= load_par;
        end else if (unload) begin
            hold_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/serializer.sv
// serializer: parallel-to-serial converter with per-frame word order, backpressure and a one-frame holding buffer.
module serializer
    import serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARL_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  par_valid,
    output logic                  par_ready,
    input  logic                  dir,
    input  logic [DATA_WIDTH-1:0] par [PARL_WIDTH],
    output logic [DATA_WIDTH-1:0] ser,
    output logic                  ser_valid,
    input  logic                  ser_ready,
    output logic                  ser_first,
    output logic                  ser_last,
    output logic                  busy
);

    localparam int CW = $clog2(PARL_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(PARL_WIDTH - 1);

    ser_state_e            state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shreg    [PARL_WIDTH];
    logic [DATA_WIDTH-1:0] ld_frame [PARL_WIDTH];
    logic [DATA_WIDTH-1:0] hold_par [PARL_WIDTH];
    logic                  hold_vld, hold_dir;
    logic                  accept, xfer, at_last, hold_load, hold_unload;

    assign par_ready   = !hold_vld;
    assign ser_valid   = state == SHIFT;
    assign accept      = par_valid & par_ready;
    assign xfer        = ser_valid & ser_ready;
    assign at_last     = ser_valid & (cnt == CNT_LAST);
    assign ser_first   = ser_valid & (cnt == '0);
    assign ser_last    = at_last;
    assign busy        = ser_valid | hold_vld;
    assign ser         = shreg[0];
    assign hold_load   = accept & ser_valid & !(xfer & at_last);
    assign hold_unload = xfer & at_last & hold_vld;

    // Shifter loads in transmit order, so slot 0 is always the word on ser.
    for (genvar g = 0; g < PARL_WIDTH; g++) begin : g_ord
        localparam int FWD = word_sel(1'b0, g, PARL_WIDTH);
        localparam int REV = word_sel(1'b1, g, PARL_WIDTH);
        assign ld_frame[g] = hold_vld ? (hold_dir ? hold_par[REV] : hold_par[FWD])
                                      : (dir ? par[REV] : par[FWD]);
    end

    ser_frame_buf #(.DATA_WIDTH(DATA_WIDTH), .PARL_WIDTH(PARL_WIDTH)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .unload   (hold_unload),
        .load_dir (dir),
        .load_par (par),
        .hold_vld (hold_vld),
        .hold_dir (hold_dir),
        .hold_par (hold_par)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '{default: '0};
        end else if (state == IDLE) begin
            if (accept) begin
                state <= SHIFT;
                cnt   <= '0;
                shreg <= ld_frame;
            end
        end else if (xfer) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
            for (int i = 0; i < PARL_WIDTH - 1; i++) shreg[i] <= shreg[i+1];
            shreg[PARL_WIDTH-1] <= '0;
            // On the final beat a held or freshly offered frame follows with no idle beat.
            if (at_last && (hold_vld || accept)) shreg <= ld_frame;
            else if (at_last) state <= IDLE;
        end
    end

endmodule

// File: tb/tb_serializer.sv
// tb_serializer: directed and random stimulus against a word-queue reference model with deserializer-style round-trip check.
module tb_serializer;

    localparam int DW = 8;
    localparam int PW = 4;

    typedef struct {
        logic [DW-1:0] w;
        logic          f;
        logic          l;
        logic          d;
    } beat_t;

    logic          clk = 1'b0, rst = 1'b0;
    logic          par_valid = 1'b0, dir = 1'b0, ser_ready = 1'b1;
    logic          par_ready, ser_valid, ser_first, ser_last, busy;
    logic [DW-1:0] par [PW];
    logic [DW-1:0] ser;

    beat_t         q[$];
    logic [31:0]   sent[$];
    logic [DW-1:0] rx [PW];
    int            rx_n = 0;
    int            pat_i = 0;
    logic          last_acc;
    int            errors = 0, checks = 0;

    always #5 clk = ~clk;

    serializer #(.DATA_WIDTH(DW), .PARL_WIDTH(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .dir       (dir),
        .par       (par),
        .ser       (ser),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int outstanding();
        return (q.size() + PW - 1) / PW;
    endfunction

    task automatic check_outputs();
        chk("ser_valid", {31'b0, ser_valid}, {31'b0, q.size() > 0});
        chk("busy", {31'b0, busy}, {31'b0, q.size() > 0});
        chk("par_ready", {31'b0, par_ready}, {31'b0, outstanding() < 2});
        if (q.size() > 0) begin
            chk("ser", {24'b0, ser}, {24'b0, q[0].w});
            chk("ser_first", {31'b0, ser_first}, {31'b0, q[0].f});
            chk("ser_last", {31'b0, ser_last}, {31'b0, q[0].l});
        end
    endtask

    task automatic set_ready(input int mode);
        if (mode == 1) ser_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
        else if (mode == 2) ser_ready = 1'($urandom_range(0, 1));
        else ser_ready = 1'b1;
        pat_i++;
    endtask

    task automatic tick();
        beat_t       b;
        logic [31:0] got;
        logic        acc, xf;
        acc = par_valid && (outstanding() < 2);
        xf  = (q.size() > 0) && ser_ready;
        last_acc = acc;
        if (xf) begin
            b = q.pop_front();
            rx[b.d ? PW - 1 - rx_n : rx_n] = b.w;
            rx_n++;
            if (rx_n == PW) begin
                rx_n = 0;
                for (int i = 0; i < PW; i++) got[i*DW +: DW] = rx[i];
                chk("roundtrip", got, sent.pop_front());
            end
        end
        if (acc) begin
            logic [31:0] f;
            for (int k = 0; k < PW; k++) begin
                q.push_back('{par[dir ? PW - 1 - k : k], k == 0, k == PW - 1, dir});
                f[k*DW +: DW] = par[k];
            end
            sent.push_back(f);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [31:0] f, input logic d, input int mode);
        for (int i = 0; i < PW; i++) par[i] = f[i*DW +: DW];
        dir = d;
        par_valid = 1'b1;
        last_acc = 1'b0;
        for (int i = 0; i < 60 && !last_acc; i++) begin
            set_ready(mode);
            tick();
        end
        chk("accept_timeout", {31'b0, last_acc}, 32'd1);
        par_valid = 1'b0;
    endtask

    task automatic drain(input int mode);
        for (int i = 0; i < 200 && q.size() > 0; i++) begin
            set_ready(mode);
            tick();
        end
        ser_ready = 1'b1;
        chk("drain_timeout", q.size(), 32'd0);
    endtask

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            set_ready(mode);
            tick();
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        par_valid = 1'b0;
        #1;
        q.delete();
        sent.delete();
        rx_n = 0;
        chk("rst_ser", {24'b0, ser}, 32'd0);
        chk("rst_ser_valid", {31'b0, ser_valid}, 32'd0);
        chk("rst_ser_first", {31'b0, ser_first}, 32'd0);
        chk("rst_ser_last", {31'b0, ser_last}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_par_ready", {31'b0, par_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < PW; i++) par[i] = '0;
        #2;
        pulse_rst();
        check_outputs();

        // 1: in-order frame, word 0 appears the cycle after accept
        send(32'h44332211, 1'b0, 0);
        chk("t1_word0", {24'b0, ser}, 32'h11);
        drain(0);
        run(2, 0);

        // 2: reversed order
        send(32'h44332211, 1'b1, 0);
        chk("t2_word0", {24'b0, ser}, 32'h44);
        drain(0);

        // 3: three frames back-to-back, mixed order
        send($urandom, 1'b0, 0);
        send($urandom, 1'b1, 0);
        send($urandom, 1'b0, 0);
        drain(0);

        // 4: stall pattern 1,0,0,1 during a frame
        pat_i = 0;
        send($urandom, 1'b0, 1);
        drain(1);
        send($urandom, 1'b1, 1);
        send($urandom, 1'b0, 1);
        drain(1);

        // 5: reset on beat 2 with a second frame held
        send(32'hA3A2A1A0, 1'b0, 0);
        send(32'hB3B2B1B0, 1'b1, 0);
        run(1, 0);
        chk("t5_beat2", {24'b0, ser}, 32'hA2);
        chk("t5_held", {31'b0, par_ready}, 32'd0);
        pulse_rst();
        run(1, 0);
        send(32'hC3C2C1C0, 1'b0, 0);
        chk("t5_restart", {24'b0, ser}, 32'hC0);
        drain(0);

        // 6: random frames, order, gaps and backpressure
        for (int n = 0; n < 40; n++) begin
            run($urandom_range(0, 2), 2);
            send($urandom, 1'($urandom_range(0, 1)), 2);
        end
        drain(2);
        chk("scoreboard_empty", sent.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
